// File: rtl/fp_mult_sched_if.sv
// fp_mult_sched_if: requester handshakes and shared multiplier bundle.
// Optional FP_SCHED_STICKY_STATUS_EN adds sticky_status/sticky_clr.
interface fp_mult_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [3*NREQ-1:0]  req_rnd;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [32*NREQ-1:0] rsp_z;
    logic [8*NREQ-1:0]  rsp_status;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic [2:0]         mul_rnd;
    logic [31:0]        mul_z;
    logic [7:0]         mul_status;
`ifdef FP_SCHED_STICKY_STATUS_EN
    logic [8*NREQ-1:0]  sticky_status;
    logic [NREQ-1:0]    sticky_clr;

    modport master (
        output req_valid, req_a, req_b, req_rnd, rsp_ready,
        output mul_z, mul_status, sticky_clr,
        input  req_ready, rsp_valid, rsp_z, rsp_status,
        input  mul_a, mul_b, mul_rnd, sticky_status
    );

    modport slave (
        input  req_valid, req_a, req_b, req_rnd, rsp_ready,
        input  mul_z, mul_status, sticky_clr,
        output req_ready, rsp_valid, rsp_z, rsp_status,
        output mul_a, mul_b, mul_rnd, sticky_status
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_rnd, rsp_ready,
        output mul_z, mul_status,
        input  req_ready, rsp_valid, rsp_z, rsp_status,
        input  mul_a, mul_b, mul_rnd
    );

    modport slave (
        input  req_valid, req_a, req_b, req_rnd, rsp_ready,
        input  mul_z, mul_status,
        output req_ready, rsp_valid, rsp_z, rsp_status,
        output mul_a, mul_b, mul_rnd
    );
`endif
endinterface

// File: rtl/fp_mult_sched.sv
// fp_mult_sched: round-robin sharing of one pipelined FP multiplier.
// Optional FP_SCHED_STICKY_STATUS_EN keeps an OR of statuses per requester.
module fp_mult_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic           clk,
    input  logic           rst,
    fp_mult_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    typedef logic [IW-1:0] id_t;

    logic [NREQ-1:0] r_busy;
    id_t             r_ptr;
    logic [LAT:0]    r_tag_v;
    id_t             r_tag_id [LAT+1];
    logic [NREQ-1:0] r_rsp_valid;
    logic [31:0]     r_rsp_z [NREQ];
    logic [7:0]      r_rsp_st [NREQ];
    logic [31:0]     r_mul_a;
    logic [31:0]     r_mul_b;
    logic [2:0]      r_mul_rnd;

    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   w_grant;
    logic [NREQ-1:0]   w_done;
    logic              w_acc;
    id_t               w_gid;
    logic              w_cap;
    id_t               w_cap_id;
    logic [31:0]       w_a [NREQ];
    logic [31:0]       w_b [NREQ];
    logic [2:0]        w_rnd [NREQ];
    logic [32*NREQ-1:0] w_rsp_z;
    logic [8*NREQ-1:0]  w_rsp_st;

    assign w_elig   = bus.req_valid & ~r_busy;
    assign w_done   = r_rsp_valid & bus.rsp_ready;
    assign w_cap    = r_tag_v[LAT];
    assign w_cap_id = r_tag_id[LAT];

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_a[k]   = bus.req_a[32*k +: 32];
            w_b[k]   = bus.req_b[32*k +: 32];
            w_rnd[k] = bus.req_rnd[3*k +: 3];
        end
    end

    // Lowest eligible index above ptr wins, else lowest at or below ptr.
    always_comb begin
        w_acc = 1'b0;
        w_gid = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_elig[i] && (id_t'(i) <= r_ptr)) begin
                w_acc = 1'b1;
                w_gid = id_t'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_elig[i] && (id_t'(i) > r_ptr)) begin
                w_acc = 1'b1;
                w_gid = id_t'(i);
            end
        end
        if (rst) begin
            w_acc = 1'b0;
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_acc) begin
            w_grant[w_gid] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_ptr       <= id_t'(NREQ - 1);
            r_tag_v     <= '0;
            r_rsp_valid <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_rnd   <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_tag_id[s] <= '0;
            end
            for (int k = 0; k < NREQ; k++) begin
                r_rsp_z[k]  <= '0;
                r_rsp_st[k] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[LAT-1:0], w_acc};
            r_tag_id[0] <= w_gid;
            for (int s = 1; s <= LAT; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
            r_busy      <= (r_busy | w_grant) & ~w_done;
            r_rsp_valid <= r_rsp_valid & ~w_done;
            if (w_acc) begin
                r_mul_a   <= w_a[w_gid];
                r_mul_b   <= w_b[w_gid];
                r_mul_rnd <= w_rnd[w_gid];
                r_ptr     <= w_gid;
            end
            // A captured id is busy with no held response, so no clash.
            if (w_cap) begin
                r_rsp_valid[w_cap_id] <= 1'b1;
                r_rsp_z[w_cap_id]     <= bus.mul_z;
                r_rsp_st[w_cap_id]    <= bus.mul_status;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_rsp_z[32*k +: 32] = r_rsp_z[k];
            w_rsp_st[8*k +: 8]  = r_rsp_st[k];
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_z      = w_rsp_z;
    assign bus.rsp_status = w_rsp_st;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.mul_rnd    = r_mul_rnd;

`ifdef FP_SCHED_STICKY_STATUS_EN
    logic [7:0]        r_sticky [NREQ];
    logic [8*NREQ-1:0] w_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREQ; k++) begin
                r_sticky[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (w_cap && (w_cap_id == id_t'(k))) begin
                    r_sticky[k] <= bus.sticky_clr[k] ? bus.mul_status
                                 : (r_sticky[k] | bus.mul_status);
                end else if (bus.sticky_clr[k]) begin
                    r_sticky[k] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_sticky[8*k +: 8] = r_sticky[k];
        end
    end

    assign bus.sticky_status = w_sticky;
`endif
endmodule

// File: tb/tb_fp_mult_sched.sv
// tb_fp_mult_sched: directed vectors, queue scoreboard and response monitor.
// A table-driven LAT-deep stub stands in for the shared multiplier.
module tb_fp_mult_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rnd;
        logic [31:0] z;
        logic [7:0]  st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_mult_sched_if #(.NREQ(NREQ)) bus ();

    fp_mult_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t vt [9];
    vec_t pend [NREQ][$];
    vec_t sb [NREQ][$];

    int nvec = 0;
    int nfail = 0;
    logic [NREQ-1:0] last_grant = '0;
    logic [NREQ-1:0] rr = '0;
    logic [NREQ-1:0] clr_set = '0;
    logic rst_set = 1'b1;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b,
                                logic [2:0] rnd, logic [31:0] z,
                                logic [7:0] st);
        vec_t v;
        v.a = a;
        v.b = b;
        v.rnd = rnd;
        v.z = z;
        v.st = st;
        return v;
    endfunction

    function automatic logic [39:0] lookup(logic [31:0] a, logic [31:0] b,
                                           logic [2:0] rnd);
        for (int i = 0; i < 9; i++) begin
            if (vt[i].a === a && vt[i].b === b && vt[i].rnd === rnd)
                return {vt[i].z, vt[i].st};
        end
        return {32'hBAD0BAD0, 8'hFF};
    endfunction

    // Multiplier stub: result appears LAT edges after operands are sampled.
    logic [39:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= lookup(bus.mul_a, bus.mul_b, bus.mul_rnd);
        for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
    end
    assign bus.mul_z      = mpipe[LAT-1][39:8];
    assign bus.mul_status = mpipe[LAT-1][7:0];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        rst = rst_set;
        bus.rsp_ready = rr;
`ifdef FP_SCHED_STICKY_STATUS_EN
        bus.sticky_clr = clr_set;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i].size() > 0) begin
                bus.req_valid[i] = 1'b1;
                bus.req_a[32*i +: 32] = pend[i][0].a;
                bus.req_b[32*i +: 32] = pend[i][0].b;
                bus.req_rnd[3*i +: 3] = pend[i][0].rnd;
            end else begin
                bus.req_valid[i] = 1'b0;
            end
        end
        #1;
        last_grant = bus.req_ready;
        chk("grant_onehot", 32'($onehot0(last_grant)), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (last_grant[i]) begin
                if (pend[i].size() == 0)
                    chk($sformatf("grant_valid[%0d]", i),
                        32'(bus.req_valid[i]), 32'd1);
                else
                    sb[i].push_back(pend[i].pop_front());
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_set = 1'b1;
        repeat (n) cycle();
        rst_set = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i].delete();
            sb[i].delete();
        end
    endtask

    function automatic bit outstanding();
        for (int i = 0; i < NREQ; i++)
            if (pend[i].size() > 0 || sb[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string nm);
        int n = 0;
        while (outstanding() && n < 200) begin
            cycle();
            n++;
        end
        chk({nm, "_drain"}, 32'(n < 200), 32'd1);
        repeat (2) cycle();
    endtask

    // Monitor: a result is checked on the edge the requester consumes it.
    always begin : mon
        vec_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (bus.rsp_valid[k] && bus.rsp_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL rsp_unexpected[%0d]: got z=%h",
                                 k, bus.rsp_z[32*k +: 32]);
                    end else begin
                        e = sb[k].pop_front();
                        chk($sformatf("rsp_z[%0d]", k),
                            bus.rsp_z[32*k +: 32], e.z);
                        chk($sformatf("rsp_status[%0d]", k),
                            32'(bus.rsp_status[8*k +: 8]), 32'(e.st));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n_g2;
        int n_oth;
        int ng;
        logic [31:0] held;
        logic stable;
        logic ok;

        vt[0] = mk(32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 8'h00);
        vt[1] = mk(32'h00000000, 32'h3F800000, 3'd1, 32'h00000000, 8'h01);
        vt[2] = mk(32'h3F800000, 32'h40000000, 3'd2, 32'h40000000, 8'h00);
        vt[3] = mk(32'h40400000, 32'h40400000, 3'd3, 32'h41100000, 8'h00);
        vt[4] = mk(32'hC0000000, 32'h40000000, 3'd4, 32'hC0800000, 8'h00);
        vt[5] = mk(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04);
        vt[6] = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 32'h7F800000, 8'h20);
        vt[7] = mk(32'h3FC00000, 32'h3FC00000, 3'd1, 32'h40100000, 8'h00);
        vt[8] = mk(32'hBF800000, 32'h3F800000, 3'd0, 32'hBF800000, 8'h00);

        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_rnd = '0;
        bus.rsp_ready = '0;
`ifdef FP_SCHED_STICKY_STATUS_EN
        bus.sticky_clr = '0;
`endif

        // Reset: valid requests present but no grant while rst is high
        for (int i = 0; i < NREQ; i++) pend[i].push_back(vt[0]);
        do_reset(3);
        chk("rst_req_ready", 32'(last_grant), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_z", 32'(|bus.rsp_z), 32'd0);
        chk("rst_rsp_status", 32'(|bus.rsp_status), 32'd0);
        chk("rst_mul_a", bus.mul_a, 32'd0);
        chk("rst_mul_b", bus.mul_b, 32'd0);
        chk("rst_mul_rnd", 32'(bus.mul_rnd), 32'd0);

        // Single request, latency LAT+1
        rr = '1;
        pend[0].push_back(vt[0]);
        cycle();
        chk("t1_grant", 32'(last_grant), 32'h1);
        cycle();
        chk("t1_mul_a", bus.mul_a, 32'h40000000);
        chk("t1_mul_b", bus.mul_b, 32'h40400000);
        repeat (2) cycle();
        chk("t1_lat_early", 32'(bus.rsp_valid[0]), 32'd0);
        cycle();
        chk("t1_lat_valid", 32'(bus.rsp_valid[0]), 32'd1);
        chk("t1_z", bus.rsp_z[31:0], 32'h40C00000);
        drain("t1");

        // All four requesting: grants 0,1,2,3 on consecutive cycles
        do_reset(1);
        for (int i = 0; i < NREQ; i++) pend[i].push_back(vt[1+i]);
        for (int i = 0; i < NREQ; i++) begin
            cycle();
            chk($sformatf("t2_grant%0d", i), 32'(last_grant), 32'(1 << i));
        end
        drain("t2");

        // Back-pressure on requester 2
        rr = 4'b1011;
        pend[2].push_back(vt[7]);
        pend[2].push_back(vt[8]);
        pend[0].push_back(vt[0]);
        pend[0].push_back(vt[2]);
        pend[1].push_back(vt[3]);
        pend[1].push_back(vt[4]);
        n_g2 = 0;
        n_oth = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            n_g2 += int'(last_grant[2]);
            n_oth += int'(last_grant[0]) + int'(last_grant[1]);
            if (bus.rsp_valid[2]) break;
        end
        chk("t3_rsp2_valid", 32'(bus.rsp_valid[2]), 32'd1);
        held = bus.rsp_z[64 +: 32];
        stable = 1'b1;
        repeat (10) begin
            cycle();
            n_g2 += int'(last_grant[2]);
            n_oth += int'(last_grant[0]) + int'(last_grant[1]);
            if (bus.rsp_z[64 +: 32] !== held || !bus.rsp_valid[2])
                stable = 1'b0;
        end
        chk("t3_held_stable", 32'(stable), 32'd1);
        chk("t3_held_z", held, 32'h40100000);
        chk("t3_g2_count", n_g2, 1);
        chk("t3_others_granted", n_oth, 4);
        rr[2] = 1'b1;
        cycle();
        chk("t3_release_same", 32'(last_grant[2]), 32'd0);
        cycle();
        chk("t3_release_next", 32'(last_grant[2]), 32'd1);
        rr = '1;
        drain("t3");

        // Special operands: inf * 0
        pend[3].push_back(vt[5]);
        drain("t4");

        // Reset with three operations in flight
        rr = '0;
        pend[0].push_back(vt[2]);
        pend[1].push_back(vt[3]);
        pend[2].push_back(vt[4]);
        ng = 0;
        repeat (3) begin
            cycle();
            ng += $countones(last_grant);
        end
        chk("t5_inflight", ng, 3);
        do_reset(1);
        rr = '1;
        ok = 1'b1;
        repeat (2*LAT + 2) begin
            cycle();
            if (|bus.rsp_valid) ok = 1'b0;
        end
        chk("t5_no_stale", 32'(ok), 32'd1);
        pend[2].push_back(vt[0]);
        pend[1].push_back(vt[1]);
        pend[0].push_back(vt[8]);
        cycle();
        chk("t5_first_grant", 32'(last_grant), 32'h1);
        cycle();
        chk("t5_second_grant", 32'(last_grant), 32'h2);
        cycle();
        chk("t5_third_grant", 32'(last_grant), 32'h4);
        drain("t5");

`ifdef FP_SCHED_STICKY_STATUS_EN
        // Sticky status accumulate, then clear colliding with a capture
        do_reset(1);
        chk("t6_sticky_rst", 32'(|bus.sticky_status), 32'd0);
        rr = '1;
        pend[1].push_back(vt[1]);
        pend[1].push_back(vt[6]);
        drain("t6a");
        chk("t6_sticky_or", 32'(bus.sticky_status[15:8]), 32'h21);
        pend[1].push_back(vt[5]);
        cycle();
        chk("t6_grant", 32'(last_grant), 32'h2);
        repeat (2) cycle();
        clr_set = 4'b0010;
        cycle();
        clr_set = '0;
        cycle();
        chk("t6_clr_capture", 32'(bus.sticky_status[15:8]), 32'h04);
        drain("t6b");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/fp_mult_sched.md
# fp_mult_sched

Round-robin scheduler that shares one pipelined `fp_mult_top` single-precision multiplier among `NREQ` independent requesters. It accepts operand pairs through per-requester valid/ready handshakes and issues at most one multiply per cycle to the shared multiplier. A tag pipeline tracks each operation through the multiplier's fixed latency, and the scheduler steers each `z`/`status` result back to the requester that issued it through a per-requester response handshake. It sits between the requester blocks and the single `fp_mult_top` instance.

## Interface
- `NREQ`, default 4: number of requesters; legal values are 2 to 8.
- `LAT`, default 2: multiplier latency in clock edges. `mul_z`/`mul_status` sampled at edge t belong to the `mul_a`/`mul_b` sampled at edge t-LAT.
- `clk` in 1: single clock. The multiplier uses the same clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: requester i has an operand pair.
- `req_ready` out NREQ: grant; requester i's operands are accepted at this edge.
- `req_a`, `req_b` in 32*NREQ: operands; slice i is bits [32i+31:32i].
- `req_rnd` in 3*NREQ: rounding mode per requester.
- `rsp_valid` out NREQ: result held for requester i.
- `rsp_ready` in NREQ: requester i consumes its result.
- `rsp_z` out 32*NREQ: result word per requester.
- `rsp_status` out 8*NREQ: status byte per requester.
- `mul_a`, `mul_b` out 32: registered operands to the multiplier.
- `mul_rnd` out 3: registered rounding mode to the multiplier.
- `mul_z` in 32: result from the multiplier.
- `mul_status` in 8: status from the multiplier.

## Operation
**Busy scoreboard**
- Each requester has one `busy[i]` bit, so at most one operation per requester is ever in flight.
- Requester i is eligible when `req_valid[i] && !busy[i]`.

**Arbitration**
- `req_ready` is combinational and one-hot, or all zero.
- The grant goes to the first eligible index after round-robin pointer `ptr`, searching upward with wrap.
- `req_ready` is forced to 0 while `rst` is high.
- `req_ready[i]` depends on `req_valid[i]`. Requesters must not make `req_valid` depend on `req_ready`.

**Accept edge** (`req_valid[i] && req_ready[i]`):
- Load `mul_a`/`mul_b`/`mul_rnd` from slice i.
- Set `busy[i]`.
- Set `ptr <= i`.
- Push the tag {1, i} into tag stage 0.

**Idle cycle**
- `mul_*` hold their last value.
- Tag stage 0 is loaded invalid.

**Tag pipeline**
- `LAT+1` stages of {valid, id}. All stages shift every edge, with no stall.
- When stage `LAT` is valid with id k, that edge captures `mul_z` into `rsp_z[k]` and `mul_status` into `rsp_status[k]`, and sets `rsp_valid[k]`.

**Response**
- `rsp_valid[k]` and its data hold until `rsp_ready[k]` is high at an edge.
- That edge clears both `rsp_valid[k]` and `busy[k]`.
- Requester k becomes eligible again in the following cycle, never in the same cycle.
- No capture can collide with a held response, because `busy` limits each requester to one operation in flight.

## Timing
- Reset values:
  - `rsp_valid` = 0; `rsp_z` = 0; `rsp_status` = 0.
  - `mul_a` = `mul_b` = 0; `mul_rnd` = 0.
  - `busy` = 0; all tags invalid.
  - `ptr` = NREQ-1, so requester 0 has first priority.
- Latency: accept at edge E0 gives `rsp_valid` high after edge E0+LAT+1, which is LAT+1 cycles.
- Throughput: one accept per cycle across different requesters. A single requester can issue once every LAT+3 cycles at best, when `rsp_ready` is held high.
- Reset mid-operation:
  - All in-flight tags are discarded and `busy` is cleared.
  - Pending responses are dropped.
  - No `rsp_valid` appears after `rst` deasserts unless a new accept occurs.
- Round-robin example: if every requester is eligible, the grant order is 0, 1, ..., NREQ-1, 0, ...
- Wrap: with `ptr` = NREQ-1, the search starts at index 0.

## Configuration
- Macro `FP_SCHED_STICKY_STATUS_EN`.
- Defined:
  - Adds output `sticky_status` (8*NREQ) and input `sticky_clr` (NREQ).
  - `sticky_status[k]` ORs in every `mul_status` captured for k.
  - `sticky_clr[k]` zeroes it at the edge. A capture in the same edge wins: the register takes the new status only.
  - `sticky_status` resets to 0.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

## Test plan
- **Single request.** Requester 0 only, a=0x40000000, b=0x40400000, rnd=0, `rsp_ready` held high.
  - `req_ready[0]` is high in the same cycle.
  - `rsp_z[0]`=0x40C00000 and `rsp_status[0]`=0x00, with `rsp_valid[0]` high exactly LAT+1 cycles after accept.
- **All four requesting.** All four requesters assert valid with distinct operands.
  - Grants go in order 0, 1, 2, 3 on consecutive cycles.
  - Each result returns to the matching requester, e.g. 0x00000000×0x3F800000 → z=0, status[0]=1.
- **Back-pressure.** Requester 2 holds `rsp_ready`=0 for 10 cycles while keeping `req_valid` high.
  - `req_ready[2]` stays 0 and its result stays stable.
  - Other requesters continue to be granted.
  - Requester 2 is eligible again in the cycle after its `rsp_ready` is asserted.
- **Special operands.** 0x7F800000×0x00000000 → `rsp_status` bit 2 set.
- **Reset mid-flight.** Pulse `rst` for 1 cycle while 3 operations are in flight.
  - All `rsp_valid` are 0 afterwards and no stale response appears within 2·LAT cycles.
  - `busy` is clear and the next grant goes to requester 0.
- **Sticky status** (`FP_SCHED_STICKY_STATUS_EN`).
  - Two results for requester 1 with statuses 0x01 and 0x20 give `sticky_status[1]`=0x21.
  - `sticky_clr[1]` asserted in the same edge as a capture of 0x04 gives 0x04.
